leaf_stream_fifo: RTL and testbench
===================================

Name: leaf_stream_fifo

Overview:
- Leaf buffering stage at the bottom of the generated module hierarchy. Every generated parent instantiates its leaves with no ports, so this stage is what each leaf slot carries.
- Accepts a valid/ready byte stream from upstream, holds up to DEPTH words, and presents them in order to the downstream consumer.
- Keeps a dequeue counter and an XOR checksum of dequeued data so hierarchy-level tests can check that each leaf saw the expected traffic.

Parameters:
- DATA_W, 8, width of the data word (>=1).
- DEPTH, 4, number of storage entries. Power of two, >=2.
- CNT_W, 16, width of the dequeue counter.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream word available.
- in_ready  output  1  stage can accept a word this cycle.
- in_data  input  DATA_W  upstream word.
- out_valid  output  1  head word available.
- out_ready  input  1  downstream accepts the head word this cycle.
- out_data  output  DATA_W  head word.
- count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- deq_cnt  output  CNT_W  number of words dequeued since reset.
- deq_sum  output  DATA_W  XOR of all words dequeued since reset.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.

Behaviour:
- Reset (async assert, sync release by the environment). While rst is high:
  - wr_ptr = 0, rd_ptr = 0, count = 0.
  - deq_cnt = 0, deq_sum = 0.
  - out_valid = 0, in_ready = 1, empty = 1, full = 0.
  - out_data = 0 (head register cleared). Storage array is not reset.
- Handshakes:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - A word transfers only on a cycle where both its valid and ready are high at the clock edge.
- in_ready = !full. It is purely registered-state driven, with no combinational path from out_ready.
- out_valid = !empty. out_data = mem[rd_ptr], combinational read of registered storage. There is no path from in_data to out_data.
- Latency: a word pushed at edge N appears on out_valid/out_data after edge N; at least 1 cycle, with no empty bypass.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- count update:
  - push only: count+1.
  - pop only: count-1.
  - both, or neither: unchanged.
- Simultaneous push and pop:
  - Allowed whenever 0 < count < DEPTH.
  - When full, push cannot occur because in_ready = 0.
  - When empty, pop cannot occur because out_valid = 0.
  - Result: occupancy never exceeds DEPTH and never underflows.
- On pop:
  - deq_cnt <= deq_cnt + 1, wrapping modulo 2^CNT_W (0xFFFF -> 0x0000 at the default width).
  - deq_sum <= deq_sum ^ out_data, using the word being popped.
- Stability: while out_valid = 1 and out_ready = 0, out_data and out_valid hold stable.
- in_valid may drop without a transfer; upstream is not required to hold.
- Reset mid-operation: all buffered words are discarded immediately. After release, the first new word is the next one seen at out_data.
- Invariant:
  - count == (wr_ptr - rd_ptr) mod DEPTH, except count == DEPTH when the pointers are equal and full.
  - full and empty are never high together.

Test Plan:
- Reset then idle, no valids -> in_ready=1, out_valid=0, count=0, deq_cnt=0, deq_sum=0 held for 20 cycles.
- Push 0x11, 0x22, 0x33, 0x44 with out_ready=0 -> count reaches 4, full=1, in_ready=0. A fifth in_valid with 0x55 is not accepted, and count stays 4.
- From the full state, set out_ready=1 for 4 cycles -> out_data sequence 0x11, 0x22, 0x33, 0x44, then empty=1. deq_cnt=4, deq_sum=0x44 (0x11^0x22^0x33^0x44).
- Streaming with in_valid=out_ready=1 for 10 cycles, data 0x01..0x0A -> after the first word, count stays at 1 with one push and one pop per cycle. Words emerge in order, deq_cnt reaches 9 at the end.
- Backpressure: random out_ready stalls over 64 words -> order is preserved, out_data holds stable during stalls, deq_sum matches the XOR of inputs, and pointers wrap 16 times without loss.
- Assert rst with count=3 -> outputs return to reset values asynchronously, before the next edge. A push of 0xA5 after release is the next out_data.
- deq_cnt preloaded near wrap (2^16 pops, or CNT_W=4 with 17 pops) -> deq_cnt wraps to 0 then 1, with no other state disturbed.

Source files
------------

// File: rtl/leaf_stream_fifo.sv
// Leaf buffering stage: valid/ready byte FIFO of DEPTH entries with a running
// dequeue counter and XOR checksum of every word handed downstream.
module leaf_stream_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [CNT_W-1:0]             deq_cnt,
  output logic [DATA_W-1:0]            deq_sum,
  output logic                         full,
  output logic                         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  deq_cnt_q, deq_cnt_d;
  logic [DATA_W-1:0] deq_sum_q, deq_sum_d;

  logic              full_s, empty_s;
  logic              push_s, pop_s;
  logic [DATA_W-1:0] head_s;

  // Status flags and handshakes depend only on registered occupancy, so
  // in_ready never sees out_ready combinationally.
  always_comb begin
    full_s  = (count_q == OCC_FULL);
    empty_s = (count_q == OCC_W'(0));
    push_s  = in_valid & ~full_s;
    pop_s   = out_ready & ~empty_s;
    // Storage is never reset, so the head is forced to zero while empty.
    if (empty_s) begin
      head_s = DATA_W'(0);
    end else begin
      head_s = mem_q[rd_ptr_q];
    end
  end

  // Next-state for pointers, occupancy and the dequeue statistics.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    deq_cnt_d = deq_cnt_q;
    deq_sum_d = deq_sum_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d  = rd_ptr_q + PTR_W'(1);
      deq_cnt_d = deq_cnt_q + CNT_W'(1);
      deq_sum_d = deq_sum_q ^ head_s;
    end else begin
      rd_ptr_d  = rd_ptr_q;
      deq_cnt_d = deq_cnt_q;
      deq_sum_d = deq_sum_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + OCC_W'(1);
      2'b01:   count_d = count_q - OCC_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage write port.
  always_comb begin
    mem_d = mem_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = in_data;
    end else begin
      mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= PTR_W'(0);
      rd_ptr_q  <= PTR_W'(0);
      count_q   <= OCC_W'(0);
      deq_cnt_q <= CNT_W'(0);
      deq_sum_q <= DATA_W'(0);
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      deq_cnt_q <= deq_cnt_d;
      deq_sum_q <= deq_sum_d;
    end
  end

  // Data storage, deliberately left out of reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign in_ready  = ~full_s;
  assign out_valid = ~empty_s;
  assign out_data  = head_s;
  assign count     = count_q;
  assign deq_cnt   = deq_cnt_q;
  assign deq_sum   = deq_sum_q;
  assign full      = full_s;
  assign empty     = empty_s;

endmodule

// File: tb/tb_leaf_stream_fifo.sv
// Randomized scoreboard bench for leaf_stream_fifo: stimulus queues expected
// words, a negedge monitor compares DUT outputs against a queue-based model.
module tb_leaf_stream_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 4;
  localparam int OCC_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [OCC_W-1:0]  count;
  logic [CNT_W-1:0]  deq_cnt;
  logic [DATA_W-1:0] deq_sum;
  logic              full;
  logic              empty;

  int checks = 0;
  int failures = 0;

  // Reference model: FIFO contents after the most recent edge, plus stats.
  logic [DATA_W-1:0] exp_q[$];
  int                m_pops = 0;
  logic [DATA_W-1:0] m_sum = '0;

  leaf_stream_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .deq_cnt(deq_cnt), .deq_sum(deq_sum),
    .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares visible outputs against the model, then retires a pop.
  always @(negedge clk) begin
    if (!rst) begin
      chk("count", int'(count), exp_q.size());
      chk("out_valid", int'(out_valid), int'(exp_q.size() > 0));
      chk("in_ready", int'(in_ready), int'(exp_q.size() < DEPTH));
      chk("full", int'(full), int'(exp_q.size() == DEPTH));
      chk("empty", int'(empty), int'(exp_q.size() == 0));
      chk("deq_cnt", int'(deq_cnt), m_pops % (1 << CNT_W));
      chk("deq_sum", int'(deq_sum), int'(m_sum));
      if (exp_q.size() > 0) begin
        chk("out_data", int'(out_data), int'(exp_q[0]));
        if (out_ready) begin
          m_sum = m_sum ^ exp_q.pop_front();
          m_pops++;
        end
      end
    end
  end

  // One clock of stimulus; called just after a rising edge.
  task automatic cycle(input bit v, input logic [DATA_W-1:0] d, input bit r);
    bit will_push;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    will_push = v && (exp_q.size() < DEPTH);
    @(posedge clk);
    if (will_push) exp_q.push_back(d);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) cycle(1'b0, '0, 1'b1);
    chk("drain_count", int'(count), 0);
    chk("drain_empty", int'(empty), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_count"}, int'(count), 0);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_in_ready"}, int'(in_ready), 1);
    chk({tag, "_empty"}, int'(empty), 1);
    chk({tag, "_full"}, int'(full), 0);
    chk({tag, "_out_data"}, int'(out_data), 0);
    chk({tag, "_deq_cnt"}, int'(deq_cnt), 0);
    chk({tag, "_deq_sum"}, int'(deq_sum), 0);
  endtask

  // Asynchronous reset mid-cycle; returns aligned just after a rising edge.
  task automatic apply_reset(input string tag);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1 rst = 1'b1;
    #1 check_reset_outputs(tag);
    exp_q.delete();
    m_pops = 0;
    m_sum  = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int issued;
    bit v, r;
    logic [DATA_W-1:0] d;

    apply_reset("rst0");

    // Idle after reset.
    repeat (20) cycle(1'b0, '0, 1'b0);

    // Fill to full, then a rejected fifth word.
    cycle(1'b1, 8'h11, 1'b0);
    cycle(1'b1, 8'h22, 1'b0);
    cycle(1'b1, 8'h33, 1'b0);
    cycle(1'b1, 8'h44, 1'b0);
    cycle(1'b1, 8'h55, 1'b0);
    cycle(1'b1, 8'h55, 1'b0);
    chk("full_count", int'(count), 4);
    chk("full_flag", int'(full), 1);
    chk("full_in_ready", int'(in_ready), 0);

    // Drain from full.
    repeat (4) cycle(1'b0, '0, 1'b1);
    chk("drain4_empty", int'(empty), 1);
    chk("drain4_deq_cnt", int'(deq_cnt), 4);
    chk("drain4_deq_sum", int'(deq_sum), 8'h44);

    // Streaming push+pop every cycle.
    for (int i = 1; i <= 10; i++) cycle(1'b1, DATA_W'(i), 1'b1);
    chk("stream_count", int'(count), 1);
    chk("stream_deq_cnt", int'(deq_cnt), (4 + 9) % (1 << CNT_W));
    drain();

    // Random traffic with backpressure over 64 accepted words.
    issued = 0;
    for (int guard = 0; guard < 2000 && issued < 64; guard++) begin
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      d = DATA_W'($urandom);
      if (v && exp_q.size() < DEPTH) issued++;
      cycle(v, d, r);
    end
    chk("random_issued", issued, 64);
    drain();

    // Reset with three words buffered, then a fresh word is next out.
    cycle(1'b1, 8'hC1, 1'b0);
    cycle(1'b1, 8'hC2, 1'b0);
    cycle(1'b1, 8'hC3, 1'b0);
    chk("pre_reset_count", int'(count), 3);
    apply_reset("rst_mid");
    cycle(1'b1, 8'hA5, 1'b0);
    chk("post_reset_head", int'(out_data), 8'hA5);
    drain();

    // Dequeue counter wrap: 17 pops at CNT_W=4 gives 1.
    apply_reset("rst_wrap");
    for (int i = 0; i < 18; i++) cycle(1'b1, DATA_W'(8'h30 + i), 1'b1);
    chk("wrap_deq_cnt", int'(deq_cnt), 1);
    chk("wrap_count", int'(count), 1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
